cc_miss_req_ctrl: RTL and testbench
===================================

Name: cc_miss_req_ctrl

Overview:
Issues cache-line refill reads to memory and sequences the refill datapath. Accepts miss requests from the tag-compare stage and drives the AXI AR channel with a critical-word-first WRAP burst of 8×64-bit beats. Pushes each miss address into the miss-address FIFO, which the data-fill unit consumes. Tracks outstanding bursts so the fill unit never sees more bursts than it has addresses for.

Parameters:
MAX_OUTSTANDING, 4, maximum bursts issued but not yet completed (rlast handshake); 1..15
CNT_W, 4, width of outstanding counter; must hold MAX_OUTSTANDING

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
miss_req_valid_i  input  1  miss request valid
miss_req_addr_i  input  32  miss byte address
miss_req_ready_o  output  1  request accepted when valid&ready
mem_arvalid_o  output  1  AXI AR valid
mem_arready_i  input  1  AXI AR ready
mem_araddr_o  output  32  AR address, 8-byte aligned
mem_arlen_o  output  4  burst length-1, constant 7
mem_arsize_o  output  3  constant 3 (8 bytes/beat)
mem_arburst_o  output  2  constant 2'b10 (WRAP)
mem_rvalid_i  input  1  R valid (monitor only)
mem_rready_i  input  1  R ready (monitor only)
mem_rlast_i  input  1  R last (monitor only)
miss_addr_fifo_full_i  input  1  miss-address FIFO full
miss_addr_fifo_wren_o  output  1  FIFO push strobe
miss_addr_fifo_wdata_o  output  32  FIFO push data = accepted miss_req_addr_i
outstanding_o  output  CNT_W  current outstanding burst count
busy_o  output  1  high when state!=IDLE or outstanding_o!=0
err_o  output  1  sticky: rlast completion seen with count 0

Behaviour:
- Reset (async, rst=1): state=IDLE, mem_arvalid_o=0, mem_araddr_o=0, outstanding_o=0, err_o=0, miss_addr_fifo_wren_o=0. Reset mid-burst drops the AR request and all tracking; memory-side recovery is out of scope.
- States: IDLE, ISSUE.
- IDLE: miss_req_ready_o = (outstanding_o < MAX_OUTSTANDING) & !miss_addr_fifo_full_i. Combinational, no dependence on miss_req_valid_i.
- Accept (valid&ready in IDLE): same cycle miss_addr_fifo_wren_o=1, wdata=miss_req_addr_i (combinational pass-through); register araddr={addr[31:3],3'b000}; next state ISSUE; outstanding increments at this edge.
- ISSUE: miss_req_ready_o=0; mem_arvalid_o=1; araddr held stable until mem_arready_i. On arready: next state IDLE, arvalid=0 next cycle. Minimum spacing between accepts: 2 cycles (accept, AR handshake at earliest the next cycle).
- Completion: rvalid&rready&rlast decrements outstanding by 1.
- Simultaneous accept and completion in one cycle: count unchanged.
- Completion with count 0 (and no accept that cycle): count stays 0, err_o set until reset.
- Count never exceeds MAX_OUTSTANDING: guaranteed by ready gating; no wrap.
- FIFO full blocks accept only; it does not affect an AR already in ISSUE.
- arlen/arsize/arburst: constants, driven even when arvalid=0.
- Address push precedes the first R beat of that burst by at least 2 cycles, so the fill unit's pop on first beat always finds data.

Decomposition:
- Shared package cc_pkg: AXI burst encodings (BURST_WRAP=2'b10), CC_ARLEN=4'd7, CC_ARSIZE=3'd3, line-offset/index/tag bit-field constants ([5:3],[14:6],[31:15]), state enum type.
- One natural sub-module: cc_outstanding_cnt (up/down saturating counter with underflow flag), instantiated once.

Test Plan:
- Single miss addr 0x0001_2348, arready after 3 cycles -> FIFO push 0x0001_2348 in accept cycle; araddr=0x0001_2348, arlen=7, arburst=2, arvalid held 3 cycles; outstanding 0->1; after 8 R beats with rlast -> outstanding 0, busy_o=0.
- Four back-to-back misses, arready=1, no R traffic (MAX=4) -> accepts every 2 cycles, outstanding reaches 4, fifth request sees ready=0 until one rlast completion, then accepted.
- Accept cycle coincident with rlast handshake at outstanding=2 -> outstanding stays 2.
- miss_addr_fifo_full_i=1 with valid held, outstanding=0 -> ready=0, no push, no arvalid; deassert full -> accept on that cycle.
- Spurious rlast handshake at outstanding=0 -> outstanding stays 0, err_o=1 and remains 1 until rst.
- Assert rst in ISSUE with arvalid=1 -> arvalid, outstanding, err_o drop to 0 asynchronously (before next clock edge); state IDLE after release.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: AXI burst encodings, refill burst shape,
// line address bit-fields and the miss-request FSM state type.
package cc_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    localparam logic [3:0] CC_ARLEN  = 4'd7;
    localparam logic [2:0] CC_ARSIZE = 3'd3;

    localparam int unsigned BYTE_MSB  = 2;
    localparam int unsigned WORD_LSB  = 3;
    localparam int unsigned WORD_MSB  = 5;
    localparam int unsigned INDEX_LSB = 6;
    localparam int unsigned INDEX_MSB = 14;
    localparam int unsigned TAG_LSB   = 15;
    localparam int unsigned TAG_MSB   = 31;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } cc_state_e;

    typedef struct packed {
        logic [TAG_MSB-TAG_LSB:0]     tag;
        logic [INDEX_MSB-INDEX_LSB:0] index;
        logic [WORD_MSB-WORD_LSB:0]   word;
        logic [BYTE_MSB:0]            byte_off;
    } cc_line_addr_t;

    function automatic cc_line_addr_t cc_split_addr(input logic [31:0] addr);
        cc_line_addr_t f;
        f.tag      = addr[TAG_MSB:TAG_LSB];
        f.index    = addr[INDEX_MSB:INDEX_LSB];
        f.word     = addr[WORD_MSB:WORD_LSB];
        f.byte_off = addr[BYTE_MSB:0];
        return f;
    endfunction

    // Critical-word-first: keep the requested 64-bit word, drop the byte offset.
    function automatic logic [31:0] cc_beat_addr(input cc_line_addr_t f);
        return {f.tag, f.index, f.word, 3'b000};
    endfunction

endpackage

// File: rtl/cc_outstanding_cnt.sv
// Up/down counter of refill bursts in flight; saturates at both ends and
// records a sticky underflow when a completion arrives with nothing in flight.
module cc_outstanding_cnt #(
    parameter int unsigned MAX_CNT = 4,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             underflow_q;
    logic             underflow_d;

    // Count and underflow state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= {CNT_W{1'b0}};
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    // Next count; simultaneous inc and dec cancel out.
    always_comb begin
        cnt_d       = cnt_q;
        underflow_d = underflow_q;
        case ({inc_i, dec_i})
            2'b10: begin
                if (cnt_q != CNT_W'(MAX_CNT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            2'b01: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    assign cnt_o       = cnt_q;
    assign underflow_o = underflow_q;

endmodule

// File: rtl/cc_miss_req_ctrl.sv
// Miss request controller: accepts cache misses, pushes the miss address to the
// fill FIFO and issues one critical-word-first WRAP refill burst per miss.
module cc_miss_req_ctrl
    import cc_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_req_valid_i,
    input  logic [31:0]      miss_req_addr_i,
    output logic             miss_req_ready_o,
    output logic             mem_arvalid_o,
    input  logic             mem_arready_i,
    output logic [31:0]      mem_araddr_o,
    output logic [3:0]       mem_arlen_o,
    output logic [2:0]       mem_arsize_o,
    output logic [1:0]       mem_arburst_o,
    input  logic             mem_rvalid_i,
    input  logic             mem_rready_i,
    input  logic             mem_rlast_i,
    input  logic             miss_addr_fifo_full_i,
    output logic             miss_addr_fifo_wren_o,
    output logic [31:0]      miss_addr_fifo_wdata_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             busy_o,
    output logic             err_o
);

    cc_state_e        state_q;
    cc_state_e        state_d;
    logic [31:0]      araddr_q;
    logic [31:0]      araddr_d;
    logic             accept_s;
    logic             complete_s;
    logic [CNT_W-1:0] outstanding_s;
    logic             underflow_s;

    assign complete_s = mem_rvalid_i & mem_rready_i & mem_rlast_i;
    assign accept_s   = miss_req_valid_i & miss_req_ready_o;

    cc_outstanding_cnt #(
        .MAX_CNT (MAX_OUTSTANDING),
        .CNT_W   (CNT_W)
    ) u_outstanding_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (accept_s),
        .dec_i       (complete_s),
        .cnt_o       (outstanding_s),
        .underflow_o (underflow_s)
    );

    // FSM state and captured AR address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            araddr_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
        end
    end

    // Next state; the AR address only changes on accept so it is stable in ISSUE.
    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d  = ST_ISSUE;
                    araddr_d = cc_beat_addr(cc_split_addr(miss_req_addr_i));
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_arready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs; ready gating alone keeps the counter from exceeding its limit.
    always_comb begin
        miss_req_ready_o = 1'b0;
        mem_arvalid_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((outstanding_s < CNT_W'(MAX_OUTSTANDING)) && !miss_addr_fifo_full_i) begin
                    miss_req_ready_o = 1'b1;
                end else begin
                    miss_req_ready_o = 1'b0;
                end
            end
            ST_ISSUE: begin
                mem_arvalid_o = 1'b1;
            end
            default: begin
                mem_arvalid_o = 1'b0;
            end
        endcase
    end

    assign miss_addr_fifo_wren_o  = accept_s;
    assign miss_addr_fifo_wdata_o = miss_req_addr_i;
    assign mem_araddr_o           = araddr_q;
    assign mem_arlen_o            = CC_ARLEN;
    assign mem_arsize_o           = CC_ARSIZE;
    assign mem_arburst_o          = BURST_WRAP;
    assign outstanding_o          = outstanding_s;
    assign busy_o                 = (state_q != ST_IDLE) || (outstanding_s != {CNT_W{1'b0}});
    assign err_o                  = underflow_s;

endmodule

// File: tb/tb_cc_miss_req_ctrl.sv
// Table-driven bench for cc_miss_req_ctrl with an AR address scoreboard.
module tb_cc_miss_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_req_valid_i;
    logic [31:0] miss_req_addr_i;
    logic        miss_req_ready_o;
    logic        mem_arvalid_o;
    logic        mem_arready_i;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;
    logic        mem_rvalid_i;
    logic        mem_rready_i;
    logic        mem_rlast_i;
    logic        miss_addr_fifo_full_i;
    logic        miss_addr_fifo_wren_o;
    logic [31:0] miss_addr_fifo_wdata_o;
    logic [3:0]  outstanding_o;
    logic        busy_o;
    logic        err_o;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic        ar, rv, rr, rl, fu;
        logic        e_rdy, e_wren, e_arv;
        logic [3:0]  e_out;
        logic        e_busy, e_err;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] ar_q[$];

    always #5 clk = ~clk;

    cc_miss_req_ctrl #(.MAX_OUTSTANDING(4), .CNT_W(4)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .miss_req_valid_i       (miss_req_valid_i),
        .miss_req_addr_i        (miss_req_addr_i),
        .miss_req_ready_o       (miss_req_ready_o),
        .mem_arvalid_o          (mem_arvalid_o),
        .mem_arready_i          (mem_arready_i),
        .mem_araddr_o           (mem_araddr_o),
        .mem_arlen_o            (mem_arlen_o),
        .mem_arsize_o           (mem_arsize_o),
        .mem_arburst_o          (mem_arburst_o),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rready_i           (mem_rready_i),
        .mem_rlast_i            (mem_rlast_i),
        .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
        .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
        .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
        .outstanding_o          (outstanding_o),
        .busy_o                 (busy_o),
        .err_o                  (err_o)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec=%0d actual=0x%08h expected=0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [31:0] a, input logic ar, input logic rv,
                       input logic rr, input logic rl, input logic fu, input logic e_rdy,
                       input logic e_wren, input logic e_arv, input logic [3:0] e_out,
                       input logic e_busy, input logic e_err);
        vec_t t;
        t.v = v; t.a = a; t.ar = ar; t.rv = rv; t.rr = rr; t.rl = rl; t.fu = fu;
        t.e_rdy = e_rdy; t.e_wren = e_wren; t.e_arv = e_arv; t.e_out = e_out;
        t.e_busy = e_busy; t.e_err = e_err;
        tbl.push_back(t);
    endtask

    // Drive one cycle just after posedge, check at negedge, then let the edge commit.
    task automatic apply(input vec_t t, input int idx);
        miss_req_valid_i      = t.v;
        miss_req_addr_i       = t.a;
        mem_arready_i         = t.ar;
        mem_rvalid_i          = t.rv;
        mem_rready_i          = t.rr;
        mem_rlast_i           = t.rl;
        miss_addr_fifo_full_i = t.fu;
        if (t.v && t.e_rdy) ar_q.push_back(t.a & 32'hFFFF_FFF8);
        @(negedge clk);
        chk("ready",       idx, {31'd0, miss_req_ready_o},      {31'd0, t.e_rdy});
        chk("fifo_wren",   idx, {31'd0, miss_addr_fifo_wren_o}, {31'd0, t.e_wren});
        chk("arvalid",     idx, {31'd0, mem_arvalid_o},         {31'd0, t.e_arv});
        chk("outstanding", idx, {28'd0, outstanding_o},         {28'd0, t.e_out});
        chk("busy",        idx, {31'd0, busy_o},                {31'd0, t.e_busy});
        chk("err",         idx, {31'd0, err_o},                 {31'd0, t.e_err});
        chk("ar_consts",   idx, {23'd0, mem_arlen_o, mem_arsize_o, mem_arburst_o},
                                {23'd0, 4'd7, 3'd3, 2'b10});
        if (t.e_wren) chk("fifo_wdata", idx, miss_addr_fifo_wdata_o, t.a);
        if (mem_arvalid_o) begin
            if (ar_q.size() == 0) begin
                chk("araddr_sb_empty", idx, mem_araddr_o, 32'hFFFF_FFFF);
            end else begin
                chk("araddr", idx, mem_araddr_o, ar_q[0]);
                if (mem_arready_i) void'(ar_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t  t;
        logic [31:0] b;
        rst = 1'b1;
        miss_req_valid_i = 1'b0; miss_req_addr_i = 32'd0; mem_arready_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
        miss_addr_fifo_full_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_arvalid", -1, {31'd0, mem_arvalid_o}, 32'd0);
        chk("rst_araddr",  -1, mem_araddr_o, 32'd0);
        chk("rst_out",     -1, {28'd0, outstanding_o}, 32'd0);
        chk("rst_err",     -1, {31'd0, err_o}, 32'd0);
        chk("rst_wren",    -1, {31'd0, miss_addr_fifo_wren_o}, 32'd0);
        rst = 1'b0;

        // Single miss, arready after 3 cycles, 8-beat refill with one stalled last beat.
        add(1'b1, 32'h0001_2348, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++)
            add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Four back-to-back unaligned misses fill the outstanding budget.
        for (int k = 0; k < 4; k++) begin
            b = 32'h8000_0ABF + 32'(k) * 32'h40;
            add(1'b1, b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'(k), k != 0, 1'b0);
            add(1'b1, b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(k + 1), 1'b1, 1'b0);
        end
        b = 32'h8000_0BBD;
        add(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
        add(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
        add(1'b1, b, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
        add(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0);

        // Drain to 2, then accept coincident with a completion; full during ISSUE.
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
        add(1'b1, 32'h1234_5674, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // FIFO full blocks accept with valid held; release accepts that same cycle.
        add(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        add(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        add(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        add(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);

        // Spurious completion at zero sets a sticky error.
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Async reset while the AR request is pending.
        add(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        apply(tbl[tbl.size() - 1], 900);
        chk("pre_rst_arvalid", 901, {31'd0, mem_arvalid_o}, 32'd1);
        chk("pre_rst_out",     901, {28'd0, outstanding_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_arvalid", 902, {31'd0, mem_arvalid_o}, 32'd0);
        chk("async_out",     902, {28'd0, outstanding_o}, 32'd0);
        chk("async_err",     902, {31'd0, err_o}, 32'd0);
        chk("async_busy",    902, {31'd0, busy_o}, 32'd0);
        ar_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        apply(tbl[tbl.size() - 1], 903);
        add(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        apply(tbl[tbl.size() - 1], 904);

        chk("sb_drained", 999, ar_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
